// File: rtl/ace_snoop_pkg.sv
// ace_snoop_pkg: shared types and constants for the ACE snoop port.
//   snp_state_e   - snoop FSM states (IDLE, EVAL, RESP, DATA)
//   AC_SNOOP codes the port recognises by name. Any other opcode is still
//                 accepted and answered with the datapath's response.
//   CR_RESP bit indices used when decoding or building snoop responses.
package ace_snoop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2,
    DATA = 2'd3
  } snp_state_e;

  localparam logic [3:0] READ_ONCE             = 4'b0000;
  localparam logic [3:0] READ_SHARED           = 4'b0001;
  localparam logic [3:0] READ_CLEAN            = 4'b0010;
  localparam logic [3:0] READ_NOT_SHARED_DIRTY = 4'b0011;
  localparam logic [3:0] READ_UNIQUE           = 4'b0111;

  localparam int DATA_XFER  = 0;
  localparam int PASS_DIRTY = 2;
  localparam int IS_SHARED  = 3;

endpackage

// File: rtl/ace_snoop_entry_buf.sv
// ace_snoop_entry_buf: one-entry holding register for a snoop request that
// arrives while the port is still answering the previous one.
// It is only instantiated when ACE_SNOOP_PIPE_EN is defined.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   wr_en                load wr_addr/wr_op/wr_prot and mark the entry full
//   wr_addr/op/prot      request fields to hold
//   rd_en                entry consumed; clears full
//   full                 entry holds a request
//   addr/op/prot         held request fields
module ace_snoop_entry_buf
  import ace_snoop_pkg::*;
#(
  parameter int WIDTH_A = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [WIDTH_A-1:0] wr_addr,
  input  logic [3:0]         wr_op,
  input  logic [2:0]         wr_prot,
  input  logic               rd_en,
  output logic               full,
  output logic [WIDTH_A-1:0] addr,
  output logic [3:0]         op,
  output logic [2:0]         prot
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= '0;
      op   <= '0;
      prot <= '0;
    end else if (wr_en) begin
      full <= 1'b1;
      addr <= wr_addr;
      op   <= wr_op;
      prot <= wr_prot;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ace_snoop_port.sv
// ace_snoop_port: ACE snoop-channel front end between interconnect and cache.
// Accepts AC snoop requests, hands address/opcode to the datapath, issues a
// one-cycle ac_enable evaluate pulse, registers the datapath response/data and
// returns them on CR (always) and CD (when DataTransfer is set).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   AC_VALID/READY/ADDR/SNOOP/PROT  snoop request channel from interconnect
//   CR_VALID/READY/RESP        snoop response channel
//   CD_VALID/READY/DATA/LAST   snoop data channel (single beat, LAST=1)
//   snp_addr, snp_op           latched request to the datapath
//   ac_enable                  one-cycle evaluate/commit pulse
//   dp_wr_busy                 datapath line write in progress; defers eval
//   dp_cr_resp, dp_cd_data     datapath results, valid with ac_enable
//   snoop_busy                 FSM not idle; cache controller defers fills
// Build option: define ACE_SNOOP_PIPE_EN to add a one-entry AC buffer so a
// new snoop can be accepted while the previous one is still responding.
module ace_snoop_port
  import ace_snoop_pkg::*;
#(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_D = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               AC_VALID,
  output logic               AC_READY,
  input  logic [WIDTH_A-1:0] AC_ADDR,
  input  logic [3:0]         AC_SNOOP,
  input  logic [2:0]         AC_PROT,
  output logic               CR_VALID,
  input  logic               CR_READY,
  output logic [4:0]         CR_RESP,
  output logic               CD_VALID,
  input  logic               CD_READY,
  output logic [WIDTH_D-1:0] CD_DATA,
  output logic               CD_LAST,
  output logic [WIDTH_A-1:0] snp_addr,
  output logic [3:0]         snp_op,
  output logic               ac_enable,
  input  logic               dp_wr_busy,
  input  logic [4:0]         dp_cr_resp,
  input  logic [WIDTH_D-1:0] dp_cd_data,
  output logic               snoop_busy
);

  snp_state_e         state, state_nxt;
  logic [4:0]         resp_q;
  logic [WIDTH_D-1:0] data_q;
  logic [WIDTH_A-1:0] addr_q;
  logic [3:0]         op_q;
  logic [2:0]         prot_q;
  logic               ac_ready, eval_go, leave, load_snp, gap_ok;
  logic [WIDTH_A-1:0] ld_addr;
  logic [3:0]         ld_op;
  logic [2:0]         ld_prot;
  // Protection is held with the request but nothing downstream consumes it.
  logic               unused_prot;

`ifdef ACE_SNOOP_PIPE_EN
  logic               buf_wr, buf_rd, buf_full;
  logic [WIDTH_A-1:0] buf_addr;
  logic [3:0]         buf_op;
  logic [2:0]         buf_prot;
  logic [1:0]         gap_q;

  ace_snoop_entry_buf #(.WIDTH_A(WIDTH_A)) u_entry_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr),
    .wr_addr (AC_ADDR),
    .wr_op   (AC_SNOOP),
    .wr_prot (AC_PROT),
    .rd_en   (buf_rd),
    .full    (buf_full),
    .addr    (buf_addr),
    .op      (buf_op),
    .prot    (buf_prot)
  );

  // Counts cycles since the last ac_enable (saturating at 3). Evaluation is
  // allowed once it reaches 2, keeping consecutive pulses >= 3 cycles apart
  // even when a buffered snoop chains straight from RESP back into EVAL.
  always_ff @(posedge clk) begin
    if (!rst_n)            gap_q <= 2'd3;
    else if (eval_go)      gap_q <= 2'd0;
    else if (gap_q != 2'd3) gap_q <= gap_q + 2'd1;
  end
  assign gap_ok = gap_q[1];
`else
  assign gap_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    eval_go   = 1'b0;
    leave     = 1'b0;
    load_snp  = 1'b0;
    ld_addr   = AC_ADDR;
    ld_op     = AC_SNOOP;
    ld_prot   = AC_PROT;
`ifdef ACE_SNOOP_PIPE_EN
    buf_wr    = 1'b0;
    buf_rd    = 1'b0;
    ac_ready  = rst_n && (state != EVAL) && !buf_full;
`else
    ac_ready  = rst_n && (state == IDLE);
`endif
    case (state)
      IDLE: if (AC_VALID && ac_ready) begin
        load_snp  = 1'b1;
        state_nxt = EVAL;
      end
      EVAL: if (rst_n && !dp_wr_busy && gap_ok) begin
        eval_go   = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (CR_READY) begin
        if (resp_q[DATA_XFER]) state_nxt = DATA;
        else                   leave     = 1'b1;
      end
      DATA: if (CD_READY) leave = 1'b1;
      default: state_nxt = IDLE;
    endcase

    if (leave) begin
      state_nxt = IDLE;
`ifdef ACE_SNOOP_PIPE_EN
      // A pending snoop (buffered, or arriving this very cycle) goes straight
      // to evaluation without an IDLE bubble.
      if (buf_full) begin
        buf_rd    = 1'b1;
        load_snp  = 1'b1;
        ld_addr   = buf_addr;
        ld_op     = buf_op;
        ld_prot   = buf_prot;
        state_nxt = EVAL;
      end else if (AC_VALID && ac_ready) begin
        load_snp  = 1'b1;
        state_nxt = EVAL;
      end
`endif
    end

`ifdef ACE_SNOOP_PIPE_EN
    if ((state == RESP || state == DATA) && AC_VALID && ac_ready && !leave)
      buf_wr = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      op_q   <= '0;
      prot_q <= '0;
      resp_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_snp) begin
        addr_q <= ld_addr;
        op_q   <= ld_op;
        prot_q <= ld_prot;
      end
      if (eval_go) begin
        resp_q <= dp_cr_resp;
        data_q <= dp_cd_data;
      end
    end
  end

  assign unused_prot = ^prot_q;

  assign AC_READY   = ac_ready;
  assign ac_enable  = eval_go;
  assign CR_VALID   = (state == RESP);
  assign CR_RESP    = resp_q;
  assign CD_VALID   = (state == DATA);
  assign CD_LAST    = (state == DATA);
  assign CD_DATA    = data_q;
  assign snp_addr   = addr_q;
  assign snp_op     = op_q;
  assign snoop_busy = (state != IDLE);

endmodule

// File: tb/tb_ace_snoop_port.sv
// tb_ace_snoop_port: directed self-checking bench for ace_snoop_port.
// Inputs change 1ns after the rising edge; outputs are sampled at the falling
// edge. The buffered-snoop scenario runs only when ACE_SNOOP_PIPE_EN is set.
module tb_ace_snoop_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        AC_VALID, AC_READY;
  logic [31:0] AC_ADDR;
  logic [3:0]  AC_SNOOP;
  logic [2:0]  AC_PROT;
  logic        CR_VALID, CR_READY;
  logic [4:0]  CR_RESP;
  logic        CD_VALID, CD_READY, CD_LAST;
  logic [31:0] CD_DATA;
  logic [31:0] snp_addr;
  logic [3:0]  snp_op;
  logic        ac_enable, dp_wr_busy, snoop_busy;
  logic [4:0]  dp_cr_resp;
  logic [31:0] dp_cd_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ace_snoop_port #(.WIDTH_A(32), .WIDTH_D(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .AC_VALID   (AC_VALID),
    .AC_READY   (AC_READY),
    .AC_ADDR    (AC_ADDR),
    .AC_SNOOP   (AC_SNOOP),
    .AC_PROT    (AC_PROT),
    .CR_VALID   (CR_VALID),
    .CR_READY   (CR_READY),
    .CR_RESP    (CR_RESP),
    .CD_VALID   (CD_VALID),
    .CD_READY   (CD_READY),
    .CD_DATA    (CD_DATA),
    .CD_LAST    (CD_LAST),
    .snp_addr   (snp_addr),
    .snp_op     (snp_op),
    .ac_enable  (ac_enable),
    .dp_wr_busy (dp_wr_busy),
    .dp_cr_resp (dp_cr_resp),
    .dp_cd_data (dp_cd_data),
    .snoop_busy (snoop_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1ns after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then sample at the falling edge.
  task automatic smp();
    #4;
  endtask

  // Offer one AC request in the current cycle; returns 1ns after the edge
  // that accepts it (start of EVAL cycle).
  task automatic offer_ac(input logic [31:0] a, input logic [3:0] op);
    AC_VALID = 1'b1;
    AC_ADDR  = a;
    AC_SNOOP = op;
    AC_PROT  = 3'b010;
    smp();
    chk("ac_ready_idle", AC_READY, 1'b1);
    tick();
    AC_VALID = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; AC_VALID = 1'b0; AC_ADDR = '0; AC_SNOOP = '0; AC_PROT = '0;
    CR_READY = 1'b0; CD_READY = 1'b0; dp_wr_busy = 1'b0;
    dp_cr_resp = '0; dp_cd_data = '0;

    // Power-on reset
    tick(); tick();
    smp();
    chk("rst_ac_ready", AC_READY, 1'b0);
    chk("rst_cr_valid", CR_VALID, 1'b0);
    chk("rst_cd_valid", CD_VALID, 1'b0);
    chk("rst_busy", snoop_busy, 1'b0);
    chk("rst_cr_resp", CR_RESP, 5'd0);
    chk("rst_snp_addr", snp_addr, 32'd0);
    tick();
    rst_n = 1'b1;
    smp();
    chk("rel_ac_ready", AC_READY, 1'b1);

    // ReadShared hit with data
    tick();
    dp_cr_resp = 5'b01001;
    dp_cd_data = 32'hDEADBEEF;
    offer_ac(32'h0000_0044, 4'b0001);
    smp();
    chk("t2_ac_enable_c1", ac_enable, 1'b1);
    chk("t2_snp_addr", snp_addr, 32'h44);
    chk("t2_snp_op", snp_op, 4'b0001);
    chk("t2_ac_ready_eval", AC_READY, 1'b0);
    chk("t2_busy", snoop_busy, 1'b1);
    tick();
    dp_cr_resp = 5'b00000;
    dp_cd_data = 32'h0;
    smp();
    chk("t2_ac_enable_c2", ac_enable, 1'b0);
    chk("t2_cr_valid", CR_VALID, 1'b1);
    chk("t2_cr_resp", CR_RESP, 5'b01001);
    chk("t2_cd_valid_c2", CD_VALID, 1'b0);
    tick();
    CR_READY = 1'b1;
    tick();
    CR_READY = 1'b0;
    smp();
    chk("t2_cr_valid_c3", CR_VALID, 1'b0);
    chk("t2_cd_valid", CD_VALID, 1'b1);
    chk("t2_cd_data", CD_DATA, 32'hDEADBEEF);
    chk("t2_cd_last", CD_LAST, 1'b1);
    tick();
    chk("t2_cd_hold", CD_VALID, 1'b1);
    CD_READY = 1'b1;
    tick();
    CD_READY = 1'b0;
    smp();
    chk("t2_cd_done", CD_VALID, 1'b0);
    chk("t2_idle", snoop_busy, 1'b0);

    // Miss with an unnamed opcode: CR only, no CD
    tick();
    dp_cr_resp = 5'b00000;
    dp_cd_data = 32'h1234_5678;
    offer_ac(32'h0000_1000, 4'b1010);
    smp();
    chk("t3_snp_op", snp_op, 4'b1010);
    chk("t3_ac_enable", ac_enable, 1'b1);
    tick();
    CR_READY = 1'b1;
    smp();
    chk("t3_cr_valid", CR_VALID, 1'b1);
    chk("t3_cr_resp", CR_RESP, 5'b00000);
    chk("t3_cd_c2", CD_VALID, 1'b0);
    tick();
    CR_READY = 1'b0;
    smp();
    chk("t3_cd_c3", CD_VALID, 1'b0);
    chk("t3_idle", snoop_busy, 1'b0);
    chk("t3_ready_back", AC_READY, 1'b1);

    // CR back-pressure for 5 cycles; response stays registered
    tick();
    dp_cr_resp = 5'b01100;
    offer_ac(32'h0000_2000, 4'b0010);
    tick();
    dp_cr_resp = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk($sformatf("t4_cr_valid_%0d", i), CR_VALID, 1'b1);
      chk($sformatf("t4_cr_resp_%0d", i), CR_RESP, 5'b01100);
`ifndef ACE_SNOOP_PIPE_EN
      chk($sformatf("t4_ac_ready_%0d", i), AC_READY, 1'b0);
`endif
      tick();
    end
    CR_READY = 1'b1;
    tick();
    CR_READY = 1'b0;
    smp();
    chk("t4_idle", snoop_busy, 1'b0);
    chk("t4_no_cd", CD_VALID, 1'b0);

    // Datapath write busy for 3 EVAL cycles defers the evaluate pulse
    tick();
    dp_cr_resp = 5'b00000;
    dp_wr_busy = 1'b1;
    offer_ac(32'h0000_3000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk($sformatf("t5_held_%0d", i), ac_enable, 1'b0);
      chk($sformatf("t5_eval_%0d", i), snoop_busy, 1'b1);
      tick();
    end
    dp_wr_busy = 1'b0;
    smp();
    chk("t5_pulse", ac_enable, 1'b1);
    tick();
    smp();
    chk("t5_single", ac_enable, 1'b0);
    chk("t5_cr_valid", CR_VALID, 1'b1);
    tick();
    CR_READY = 1'b1;
    tick();
    CR_READY = 1'b0;

    // Reset in the middle of a response
    dp_cr_resp = 5'b01001;
    offer_ac(32'h0000_4000, 4'b0001);
    tick();
    smp();
    chk("t1_cr_before", CR_VALID, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    smp();
    chk("t1_cr_rst1", CR_VALID, 1'b0);
    chk("t1_ready_rst1", AC_READY, 1'b0);
    chk("t1_busy_rst1", snoop_busy, 1'b0);
    tick();
    smp();
    chk("t1_cr_rst2", CR_VALID, 1'b0);
    chk("t1_ready_rst2", AC_READY, 1'b0);
    chk("t1_resp_rst2", CR_RESP, 5'd0);
    tick();
    rst_n = 1'b1;
    smp();
    chk("t1_ready_rel", AC_READY, 1'b1);
    chk("t1_cd_rel", CD_VALID, 1'b0);

`ifdef ACE_SNOOP_PIPE_EN
    // Second snoop accepted during RESP, chained without an IDLE cycle
    tick();
    dp_cr_resp = 5'b01001;
    dp_cd_data = 32'hCAFE_F00D;
    offer_ac(32'h0000_0044, 4'b0001);
    tick();
    dp_cr_resp = 5'b00000;
    AC_VALID = 1'b1;
    AC_ADDR  = 32'h0000_0080;
    AC_SNOOP = 4'b0111;
    smp();
    chk("t6_cr_valid", CR_VALID, 1'b1);
    chk("t6_ready_resp", AC_READY, 1'b1);
    tick();
    smp();
    chk("t6_ready_full", AC_READY, 1'b0);
    chk("t6_addr_kept", snp_addr, 32'h44);
    tick();
    AC_VALID = 1'b0;
    CR_READY = 1'b1;
    tick();
    CR_READY = 1'b0;
    CD_READY = 1'b1;
    smp();
    chk("t6_cd_valid", CD_VALID, 1'b1);
    chk("t6_cd_data", CD_DATA, 32'hCAFE_F00D);
    chk("t6_ready_data", AC_READY, 1'b0);
    tick();
    CD_READY = 1'b0;
    smp();
    chk("t6_second_pulse", ac_enable, 1'b1);
    chk("t6_no_idle", snoop_busy, 1'b1);
    chk("t6_addr2", snp_addr, 32'h80);
    chk("t6_op2", snp_op, 4'b0111);
    tick();
    CR_READY = 1'b1;
    smp();
    chk("t6_cr2", CR_VALID, 1'b1);
    chk("t6_resp2", CR_RESP, 5'b00000);
    tick();
    CR_READY = 1'b0;
    smp();
    chk("t6_idle", snoop_busy, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
